// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Purpose  : Shared types and line-geometry helpers for the instruction-fetch
//            line buffer and its word-select mux.
// Contents : state_t      - controller state encoding (IDLE / FILL / RESP)
//            WORD_W       - native instruction word width
//            offset_bits  - word-select width for a line of n words
//            tag_bits     - tag width left over from a 30-bit word address
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bits [1:0] of a byte address are the byte lane, so a line of n words
  // consumes clog2(n) bits above them for the word select.
  function automatic int unsigned offset_bits(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned n);
    return 30 - $clog2(n);
  endfunction

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/line_word_mux.sv
`default_nettype none
// ============================================================================
// Module   : line_word_mux
// Purpose  : NUM_BLOCKS-to-1 combinational selection of one 32-bit word out
//            of a packed line. Word i lives at bits [32*i +: 32].
// Ports    : line_i  in  32*NUM_BLOCKS  packed line
//            sel_i   in  OFFSET_BITS    word index
//            word_o  out 32             selected word
// Revision : 1.0 - initial release
// ============================================================================
module line_word_mux
  import ifetch_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS  = 4,
  parameter int unsigned OFFSET_BITS = offset_bits(NUM_BLOCKS)
) (
  input  logic [WORD_W*NUM_BLOCKS-1:0] line_i,
  input  logic [OFFSET_BITS-1:0]       sel_i,
  output logic [WORD_W-1:0]            word_o
);

  logic [WORD_W-1:0] w_words [NUM_BLOCKS];

  for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_words
    assign w_words[gi] = line_i[WORD_W*gi +: WORD_W];
  end

  // NUM_BLOCKS is a power of two, so every sel_i value is a valid index.
  assign word_o = w_words[sel_i];

endmodule : line_word_mux
`default_nettype wire

// File: rtl/ifetch_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_line_buffer
// Purpose  : Single-line instruction fetch buffer between a 32-bit CPU fetch
//            port and a wide instruction memory. Hits on the held line are
//            answered in one cycle; misses issue one wide read and answer the
//            CPU straight from the returned line while filling it.
// Ports    : clk        in   1            rising-edge clock
//            reset      in   1            asynchronous active-high reset
//            cpu_valid  in   1            fetch request, held until cpu_ready
//            cpu_addr   in   32           byte address, bits [1:0] ignored
//            cpu_ready  out  1            one-cycle response pulse
//            cpu_rdata  out  32           instruction word (holds when idle)
//            mem_valid  out  1            wide read request
//            mem_ready  in   1            one-cycle memory response pulse
//            mem_addr   out  32           line-aligned byte address
//            mem_rdata  in   32*NUM_BLOCKS line data, word i at [32*i +: 32]
//            flush      in   1            invalidate the held line
//            hit_cnt    out  32           hit responses, wraps
//            miss_cnt   out  32           memory fills, wraps
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_line_buffer
  import ifetch_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_valid,
  input  logic [31:0]                  cpu_addr,
  output logic                         cpu_ready,
  output logic [31:0]                  cpu_rdata,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [31:0]                  mem_addr,
  input  logic [WORD_W*NUM_BLOCKS-1:0] mem_rdata,
  input  logic                         flush,
  output logic [31:0]                  hit_cnt,
  output logic [31:0]                  miss_cnt
);

  localparam int unsigned OFFSET_BITS = offset_bits(NUM_BLOCKS);
  localparam int unsigned TAG_BITS    = tag_bits(NUM_BLOCKS);
  localparam int unsigned LINE_W      = WORD_W * NUM_BLOCKS;

  state_t                state_q, state_d;
  logic                  line_valid_q, line_valid_d;
  logic                  flush_seen_q, flush_seen_d;
  logic [TAG_BITS-1:0]   tag_q;
  logic [LINE_W-1:0]     line_q;
  logic                  cpu_ready_q, cpu_ready_d;
  logic [31:0]           cpu_rdata_q, cpu_rdata_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;
  logic                  fill_en;

  logic [TAG_BITS-1:0]   w_tag;
  logic [OFFSET_BITS-1:0] w_sel;
  logic                  w_hit;
  logic [WORD_W-1:0]     w_line_word;
  logic [WORD_W-1:0]     w_mem_word;
  logic                  w_unused_byte_lane;

  assign w_tag = cpu_addr[31 -: TAG_BITS];
  assign w_sel = cpu_addr[2 +: OFFSET_BITS];
  assign w_unused_byte_lane = ^cpu_addr[1:0];

  // A flush presented together with a lookup must win, so it masks the hit.
  assign w_hit = line_valid_q && (tag_q == w_tag) && !flush;

  line_word_mux #(
    .NUM_BLOCKS (NUM_BLOCKS)
  ) u_line_mux (
    .line_i (line_q),
    .sel_i  (w_sel),
    .word_o (w_line_word)
  );

  // Bypass path: a fill answers the CPU from the incoming line, not from
  // line_q, which only updates on the same edge.
  line_word_mux #(
    .NUM_BLOCKS (NUM_BLOCKS)
  ) u_mem_mux (
    .line_i (mem_rdata),
    .sel_i  (w_sel),
    .word_o (w_mem_word)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_valid) state_d = w_hit ? RESP : FILL;
      FILL:    if (mem_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    cpu_ready_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    line_valid_d = line_valid_q && !flush;
    flush_seen_d = flush_seen_q;
    fill_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          if (w_hit) begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = w_line_word;
            hit_cnt_d   = hit_cnt_q + 32'd1;
          end else begin
            mem_valid_d  = 1'b1;
            mem_addr_d   = {w_tag, {(OFFSET_BITS + 2){1'b0}}};
            flush_seen_d = 1'b0;
          end
        end
      end

      FILL: begin
        // A flush during the fill cannot stop the response already owed to
        // the CPU, but the returned line must not be trusted afterwards.
        if (flush) flush_seen_d = 1'b1;
        if (mem_ready) begin
          mem_valid_d  = 1'b0;
          fill_en      = 1'b1;
          line_valid_d = !(flush_seen_q || flush);
          cpu_ready_d  = 1'b1;
          cpu_rdata_d  = w_mem_word;
          miss_cnt_d   = miss_cnt_q + 32'd1;
        end
      end

      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      line_valid_q <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      cpu_ready_q  <= cpu_ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      line_valid_q <= line_valid_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  // Line data and tag are qualified by line_valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_q <= mem_rdata;
      tag_q  <= w_tag;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule : ifetch_line_buffer
`default_nettype wire

// File: tb/tb_ifetch_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_line_buffer
// Purpose  : Self-checking bench for ifetch_line_buffer. A responder models
//            the wide memory; expectations come from a line-level model
//            (one valid bit plus the held line address) and plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_line_buffer;

  localparam int unsigned NB         = 4;
  localparam int unsigned LINE_BYTES = 4 * NB;

  logic            clk;
  logic            reset;
  logic            cpu_valid;
  logic [31:0]     cpu_addr;
  logic            cpu_ready;
  logic [31:0]     cpu_rdata;
  logic            mem_valid;
  logic            mem_ready;
  logic [31:0]     mem_addr;
  logic [32*NB-1:0] mem_rdata;
  logic            flush;
  logic [31:0]     hit_cnt;
  logic [31:0]     miss_cnt;

  ifetch_line_buffer #(.NUM_BLOCKS(NB)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_valid (cpu_valid),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .flush     (flush),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_valid;
  logic [31:0] m_line;
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  // Memory responder / monitor state
  int          mem_lat  = 2;
  bit          auto_mem = 1'b1;
  int          mcnt     = 0;
  int          pulses   = 0;
  int          mv_cycles = 0;
  int          revisit  = 0;
  logic [31:0] last_maddr = '0;
  logic        rdy_s = 1'b0;

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    logic [31:0] x;
    x = {2'b00, w};
    if (x < 32'd4) return x * 32'h11;
    return (x * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return (a / LINE_BYTES) * LINE_BYTES;
  endfunction

  // Memory: answers mem_valid after mem_lat observed cycles with a one-cycle
  // mem_ready pulse; drives junk on mem_rdata otherwise.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (auto_mem) begin
        if (mem_ready) begin
          mem_ready = 1'b0;
          for (int i = 0; i < NB; i++) mem_rdata[32*i +: 32] = $urandom;
          mcnt = 0;
        end else if (mem_valid) begin
          mcnt++;
          if (mcnt >= mem_lat) begin
            mem_ready = 1'b1;
            for (int i = 0; i < NB; i++)
              mem_rdata[32*i +: 32] = mem_word(30'(mem_addr >> 2) + 30'(i));
            mcnt = 0;
            pulses++;
          end
        end
      end
    end
  end

  always @(posedge clk) rdy_s <= mem_ready;

  always @(negedge clk) begin
    if (mem_valid) begin
      mv_cycles  <= mv_cycles + 1;
      last_maddr <= mem_addr;
    end
    if (mem_valid && rdy_s) revisit <= revisit + 1;
  end

  // One CPU fetch. fl_after: -1 none, 0 flush alongside the lookup,
  // n>0 flush sampled on the edge after edge n. Returns data, latency in
  // edges (0 on timeout), and the memory pulses / mem_valid cycles it caused.
  task automatic do_fetch(input logic [31:0] a, input int fl_after,
                          output logic [31:0] d, output int lat,
                          output int dp, output int dmv);
    int p0, v0;
    @(negedge clk);
    p0 = pulses;
    v0 = mv_cycles;
    cpu_valid = 1'b1;
    cpu_addr  = a;
    flush     = (fl_after == 0);
    lat = 0;
    d   = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      flush = 1'b0;
      if (cpu_ready) begin
        d   = cpu_rdata;
        lat = i;
        break;
      end
      if (i == fl_after) flush = 1'b1;
    end
    cpu_valid = 1'b0;
    flush     = 1'b0;
    cpu_addr  = $urandom;
    @(posedge clk); #1;
    dp  = pulses - p0;
    dmv = mv_cycles - v0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_valid = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready got %0b exp 0", cpu_ready); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata got %h exp 0", cpu_rdata); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %0b exp 0", mem_valid); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (hit_cnt !== 32'h0) begin errors++; $display("FAIL reset_hit_cnt got %h exp 0", hit_cnt); end
    checks++; if (miss_cnt !== 32'h0) begin errors++; $display("FAIL reset_miss_cnt got %h exp 0", miss_cnt); end
    @(negedge clk);
    reset = 1'b0;
    m_valid = 1'b0; m_line = '0; m_hits = '0; m_misses = '0;
  endtask

  task automatic test_cold_miss();
    logic [31:0] d; int lat, dp, dmv;
    mem_lat = 2;
    do_fetch(32'h4, -1, d, lat, dp, dmv);
    m_valid = 1'b1; m_line = 32'h0; m_misses++;
    checks++; if (dmv != 2) begin errors++; $display("FAIL cold_mem_valid_cycles got %0d exp 2", dmv); end
    checks++; if (last_maddr !== 32'h0) begin errors++; $display("FAIL cold_mem_addr got %h exp 0", last_maddr); end
    checks++; if (lat != 3) begin errors++; $display("FAIL cold_latency got %0d exp 3", lat); end
    checks++; if (d !== 32'h11) begin errors++; $display("FAIL cold_rdata got %h exp 00000011", d); end
    checks++; if (miss_cnt !== m_misses) begin errors++; $display("FAIL cold_miss_cnt got %0d exp %0d", miss_cnt, m_misses); end
    checks++; if (cpu_rdata !== 32'h11) begin errors++; $display("FAIL cold_rdata_hold got %h exp 00000011", cpu_rdata); end
  endtask

  task automatic test_seq_hits();
    logic [31:0] d; int lat, dp, dmv;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] a;
      a = 32'h8 + 32'(4 * k);
      do_fetch(a, -1, d, lat, dp, dmv);
      m_hits++;
      checks++; if (lat != 1) begin errors++; $display("FAIL hit_latency addr %h got %0d exp 1", a, lat); end
      checks++; if (d !== mem_word(a[31:2])) begin errors++; $display("FAIL hit_rdata addr %h got %h exp %h", a, d, mem_word(a[31:2])); end
      checks++; if (dmv != 0) begin errors++; $display("FAIL hit_mem_valid addr %h got %0d cycles exp 0", a, dmv); end
    end
    checks++; if (hit_cnt !== 32'd2) begin errors++; $display("FAIL hit_cnt got %0d exp 2", hit_cnt); end
  endtask

  task automatic test_line_cross();
    logic [31:0] d; int lat, dp, dmv;
    do_fetch(32'h10, -1, d, lat, dp, dmv);
    m_valid = 1'b1; m_line = 32'h10; m_misses++;
    checks++; if (last_maddr !== 32'h10) begin errors++; $display("FAIL cross_mem_addr got %h exp 00000010", last_maddr); end
    checks++; if (dp != 1) begin errors++; $display("FAIL cross_mem_pulses got %0d exp 1", dp); end
    checks++; if (d !== mem_word(30'd4)) begin errors++; $display("FAIL cross_rdata got %h exp %h", d, mem_word(30'd4)); end
    checks++; if (revisit != 0) begin errors++; $display("FAIL cross_repeat_access got %0d exp 0", revisit); end
  endtask

  task automatic test_flush();
    logic [31:0] d; int lat, dp, dmv;
    pulse_flush();
    do_fetch(32'h14, -1, d, lat, dp, dmv);
    m_valid = 1'b1; m_misses++;
    checks++; if (dp != 1) begin errors++; $display("FAIL flush_refetch_pulses got %0d exp 1", dp); end
    checks++; if (last_maddr !== 32'h10) begin errors++; $display("FAIL flush_refetch_addr got %h exp 00000010", last_maddr); end
    checks++; if (miss_cnt !== m_misses) begin errors++; $display("FAIL flush_miss_cnt got %0d exp %0d", miss_cnt, m_misses); end
    // Flush during the fill: data still delivered, line left invalid.
    do_fetch(32'h38, 1, d, lat, dp, dmv);
    m_valid = 1'b0; m_misses++;
    checks++; if (d !== mem_word(30'hE)) begin errors++; $display("FAIL midfill_flush_rdata got %h exp %h", d, mem_word(30'hE)); end
    do_fetch(32'h38, -1, d, lat, dp, dmv);
    m_valid = 1'b1; m_line = 32'h30; m_misses++;
    checks++; if (dp != 1) begin errors++; $display("FAIL midfill_flush_remiss got %0d pulses exp 1", dp); end
    checks++; if (miss_cnt !== m_misses) begin errors++; $display("FAIL midfill_miss_cnt got %0d exp %0d", miss_cnt, m_misses); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] d; int lat, dp, dmv;
    auto_mem = 1'b0;
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_addr  = 32'h24;
    @(posedge clk); #1;
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rmf_mem_valid_rise got %0b exp 1", mem_valid); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rmf_mem_valid_async got %0b exp 0", mem_valid); end
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rmf_cpu_ready_async got %0b exp 0", cpu_ready); end
    cpu_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_valid = 1'b0; m_hits = '0; m_misses = '0;
    mem_ready = 1'b1;
    for (int i = 0; i < NB; i++) mem_rdata[32*i +: 32] = mem_word(30'(8 + i));
    @(posedge clk); #1;
    mem_ready = 1'b0;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rmf_late_ready_cpu got %0b exp 0", cpu_ready); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rmf_late_ready_mem got %0b exp 0", mem_valid); end
    @(posedge clk); #1;
    checks++; if (miss_cnt !== 32'd0) begin errors++; $display("FAIL rmf_miss_cnt got %0d exp 0", miss_cnt); end
    mcnt = 0;
    auto_mem = 1'b1;
    mem_lat = 2;
    do_fetch(32'h24, -1, d, lat, dp, dmv);
    m_valid = 1'b1; m_line = 32'h20; m_misses++;
    checks++; if (dp != 1) begin errors++; $display("FAIL rmf_refetch_pulses got %0d exp 1", dp); end
    checks++; if (d !== mem_word(30'h9)) begin errors++; $display("FAIL rmf_refetch_rdata got %h exp %h", d, mem_word(30'h9)); end
  endtask

  task automatic test_counter_wrap();
    logic [31:0] d; int lat, dp, dmv;
    @(negedge clk);
    dut.hit_cnt_q = 32'hFFFF_FFFF;
    m_hits = 32'hFFFF_FFFF;
    do_fetch(32'h28, -1, d, lat, dp, dmv);
    m_hits++;
    checks++; if (hit_cnt !== m_hits) begin errors++; $display("FAIL wrap_hit_cnt got %h exp %h", hit_cnt, m_hits); end
    checks++; if (d !== mem_word(30'hA)) begin errors++; $display("FAIL wrap_rdata got %h exp %h", d, mem_word(30'hA)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    int k, p0;
    k  = 0;
    p0 = pulses;
    a  = 32'h20;
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_addr  = a;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin
        checks++; if (e != 2 * k + 1) begin errors++; $display("FAIL b2b_ready_edge got %0d exp %0d", e, 2 * k + 1); end
        checks++; if (cpu_rdata !== mem_word(a[31:2])) begin errors++; $display("FAIL b2b_rdata addr %h got %h exp %h", a, cpu_rdata, mem_word(a[31:2])); end
        k++;
        m_hits++;
        a = 32'h20 + 32'(4 * (k % 4));
        cpu_addr = a;
      end
    end
    cpu_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (k != 4) begin errors++; $display("FAIL b2b_responses got %0d exp 4", k); end
    checks++; if (pulses != p0) begin errors++; $display("FAIL b2b_mem_access got %0d exp 0", pulses - p0); end
    checks++; if (hit_cnt !== m_hits) begin errors++; $display("FAIL b2b_hit_cnt got %h exp %h", hit_cnt, m_hits); end
  endtask

  task automatic test_random();
    logic [31:0] d, a; int lat, dp, dmv, fl, r, elat;
    bit exp_hit;
    for (int it = 0; it < 60; it++) begin
      mem_lat = $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) pulse_flush();
      a = 32'($urandom_range(0, 15)) * 4;
      r = $urandom_range(0, 9);
      fl = (r == 0) ? 0 : (r < 3) ? $urandom_range(1, 3) : -1;
      exp_hit = m_valid && (line_of(a) == m_line) && (fl != 0);
      do_fetch(a, fl, d, lat, dp, dmv);
      if (exp_hit) begin
        m_hits++;
        elat = 1;
      end else begin
        m_misses++;
        m_line  = line_of(a);
        m_valid = !(fl >= 1 && fl <= mem_lat);
        elat = 1 + mem_lat;
        checks++; if (last_maddr !== line_of(a)) begin errors++; $display("FAIL rnd_mem_addr it %0d got %h exp %h", it, last_maddr, line_of(a)); end
      end
      checks++; if (d !== mem_word(a[31:2])) begin errors++; $display("FAIL rnd_rdata it %0d addr %h got %h exp %h", it, a, d, mem_word(a[31:2])); end
      checks++; if (lat != elat) begin errors++; $display("FAIL rnd_latency it %0d addr %h got %0d exp %0d", it, a, lat, elat); end
      checks++; if (dp != (exp_hit ? 0 : 1)) begin errors++; $display("FAIL rnd_mem_pulses it %0d got %0d exp %0d", it, dp, exp_hit ? 0 : 1); end
      checks++; if (hit_cnt !== m_hits) begin errors++; $display("FAIL rnd_hit_cnt it %0d got %0d exp %0d", it, hit_cnt, m_hits); end
      checks++; if (miss_cnt !== m_misses) begin errors++; $display("FAIL rnd_miss_cnt it %0d got %0d exp %0d", it, miss_cnt, m_misses); end
    end
    checks++; if (revisit != 0) begin errors++; $display("FAIL rnd_repeat_access got %0d exp 0", revisit); end
  endtask

  initial begin
    reset     = 1'b1;
    cpu_valid = 1'b0;
    cpu_addr  = '0;
    flush     = 1'b0;
    test_reset();
    test_cold_miss();
    test_seq_hits();
    test_line_cross();
    test_flush();
    test_reset_mid_fill();
    test_counter_wrap();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule : tb_ifetch_line_buffer
`default_nettype wire
